// File: rtl/tmip_act_sched_if.sv
// tmip_act_sched_if: bundles the scheduler's input-burst, datapath-command and status
// signals so the scheduler and its environment connect through one port.
//   in_valid/image_size    image-load burst and its size code (0=4x4, 1=8x8, 2=16x16)
//   in_valid2/action       action burst and per-cycle action code
//   cmd_*/cmd_ready        command offered to the datapath (valid/ready handshake)
//   dp_done                datapath finished the accepted command (one-cycle pulse)
//   set_done/set_idx       end-of-set pulse and index of that set
//   busy/proto_err         scheduler activity and protocol-violation pulse
// master: the scheduler side.  slave: the environment/datapath side.
interface tmip_act_sched_if;
  logic       in_valid;
  logic [1:0] image_size;
  logic       in_valid2;
  logic [2:0] action;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [1:0] cmd_size;
  logic       cmd_last;
  logic       cmd_ready;
  logic       dp_done;
  logic       set_done;
  logic [2:0] set_idx;
  logic       busy;
  logic       proto_err;

  modport master (
    input  in_valid, image_size, in_valid2, action, cmd_ready, dp_done,
    output cmd_valid, cmd_op, cmd_size, cmd_last, set_done, set_idx, busy, proto_err
  );

  modport slave (
    output in_valid, image_size, in_valid2, action, cmd_ready, dp_done,
    input  cmd_valid, cmd_op, cmd_size, cmd_last, set_done, set_idx, busy, proto_err
  );
endinterface

// File: rtl/tmip_act_sched.sv
// tmip_act_sched: action scheduler for the TMIP template-matching datapath.
// Latches the image size from the image-load burst, queues the action list from each
// action burst (cancelling adjacent negative/hflip pairs), then issues one command at a
// time to the datapath, waiting for dp_done between commands. Max-pool commands shrink
// the tracked image size; a max-pool on a 4x4 image is dropped without a command.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    tmip_act_sched_if.master (bursts in, commands/status out)
module tmip_act_sched #(
  parameter int unsigned QDEPTH = 8,  // power of two
  parameter int unsigned SETS   = 8
) (
  input logic              clk,
  input logic              rst_n,
  tmip_act_sched_if.master bus
);
  localparam int unsigned IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(SETS + 1);

  localparam logic [2:0] StNoImg    = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StCapture  = 3'd2;
  localparam logic [2:0] StDispatch = 3'd3;
  localparam logic [2:0] StWait     = 3'd4;
  localparam logic [2:0] StFinish   = 3'd5;

  localparam logic [2:0] OpMaxpool = 3'd3;
  localparam logic [2:0] OpNeg     = 3'd4;
  localparam logic [2:0] OpHflip   = 3'd5;
  localparam logic [2:0] OpXcorr   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [2:0]    mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]    base_size_q, base_size_d, cur_size_q, cur_size_d;
  logic [CW-1:0] set_cnt_q, set_cnt_d;
  logic          in_valid_q, in_valid2_q;
  logic          ovf_q, ovf_d;
  logic          cmd_valid_q, cmd_valid_d, cmd_last_q, cmd_last_d;
  logic [2:0]    cmd_op_q, cmd_op_d;
  logic [1:0]    cmd_size_q, cmd_size_d;
  logic          set_done_q, set_done_d, proto_err_q, proto_err_d;
  logic [2:0]    set_idx_q, set_idx_d;

  logic          q_empty, q_full, iv_rise, iv2_rise, take, push, ovf_seen;
  logic [PW-1:0] head_inc, tail_dec;
  logic [2:0]    head_ent, tail_ent;

  assign q_empty  = (head_q == tail_q);
  assign q_full   = (head_q[PW-1] != tail_q[PW-1]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
  assign head_inc = head_q + PW'(1);
  assign tail_dec = tail_q - PW'(1);
  assign head_ent = mem_q[head_q[IW-1:0]];
  assign tail_ent = mem_q[tail_dec[IW-1:0]];
  assign iv_rise  = bus.in_valid & ~in_valid_q;
  assign iv2_rise = bus.in_valid2 & ~in_valid2_q;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    base_size_d = base_size_q;
    cur_size_d  = cur_size_q;
    set_cnt_d   = set_cnt_q;
    ovf_d       = ovf_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_size_d  = cmd_size_q;
    cmd_last_d  = cmd_last_q;
    set_done_d  = 1'b0;
    set_idx_d   = set_idx_q;
    proto_err_d = 1'b0;
    take        = 1'b0;
    push        = 1'b0;
    // A fresh burst starts with a clear overflow flag.
    ovf_seen    = (state_q == StCapture) ? ovf_q : 1'b0;

    if (iv_rise && (state_q == StCapture || state_q == StDispatch || state_q == StWait)) begin
      proto_err_d = 1'b1;
    end
    // NOIMG is also the post-reset state, so late dp_done pulses are tolerated there.
    if (bus.dp_done && state_q != StWait && state_q != StNoImg) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      StNoImg, StIdle: begin
        if (iv_rise) begin
          base_size_d = (bus.image_size == 2'd3) ? 2'd2 : bus.image_size;
          if (bus.image_size == 2'd3) proto_err_d = 1'b1;
          set_cnt_d = '0;
          state_d   = StIdle;
        end else if (state_q == StNoImg) begin
          if (iv2_rise) proto_err_d = 1'b1;
        end else if (bus.in_valid2) begin
          cur_size_d = base_size_q;
          ovf_d      = 1'b0;
          take       = 1'b1;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        if (bus.in_valid2) begin
          take = 1'b1;
        end else begin
          if (q_empty || tail_ent != OpXcorr) proto_err_d = 1'b1;
          state_d = StDispatch;
        end
      end
      StDispatch: begin
        if (cmd_valid_q) begin
          if (bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
            state_d     = StWait;
          end
        end else if (q_empty) begin
          state_d = StFinish;
        end else begin
          head_d = head_inc;
          // Max-pool on 4x4 is consumed without a command.
          if (!(head_ent == OpMaxpool && cur_size_q == 2'd0)) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = head_ent;
            cmd_size_d  = cur_size_q;
            cmd_last_d  = (head_inc == tail_q);
          end
        end
      end
      StWait: begin
        if (bus.dp_done) begin
          if (cmd_op_q == OpMaxpool && cur_size_q != 2'd0) cur_size_d = cur_size_q - 2'd1;
          state_d = q_empty ? StFinish : StDispatch;
        end
      end
      StFinish: begin
        set_done_d = 1'b1;
        set_idx_d  = 3'(set_cnt_q);
        set_cnt_d  = set_cnt_q + CW'(1);
        state_d    = (set_cnt_q == CW'(SETS - 1)) ? StNoImg : StIdle;
      end
      default: state_d = StNoImg;
    endcase

    if (take) begin
      if ((bus.action == OpNeg || bus.action == OpHflip) && !q_empty && tail_ent == bus.action) begin
        tail_d = tail_dec;  // adjacent pair cancels
      end else if (q_full) begin
        if (!ovf_seen) proto_err_d = 1'b1;
        ovf_d = 1'b1;
      end else begin
        push   = 1'b1;
        tail_d = tail_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q[IW-1:0]] <= bus.action;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StNoImg;
      head_q      <= '0;
      tail_q      <= '0;
      base_size_q <= '0;
      cur_size_q  <= '0;
      set_cnt_q   <= '0;
      in_valid_q  <= 1'b0;
      in_valid2_q <= 1'b0;
      ovf_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_size_q  <= '0;
      cmd_last_q  <= 1'b0;
      set_done_q  <= 1'b0;
      set_idx_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      base_size_q <= base_size_d;
      cur_size_q  <= cur_size_d;
      set_cnt_q   <= set_cnt_d;
      in_valid_q  <= bus.in_valid;
      in_valid2_q <= bus.in_valid2;
      ovf_q       <= ovf_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_size_q  <= cmd_size_d;
      cmd_last_q  <= cmd_last_d;
      set_done_q  <= set_done_d;
      set_idx_q   <= set_idx_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_size  = cmd_size_q;
  assign bus.cmd_last  = cmd_last_q;
  assign bus.set_done  = set_done_q;
  assign bus.set_idx   = set_idx_q;
  assign bus.busy      = (state_q != StNoImg) && (state_q != StIdle);
  assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_tmip_act_sched.sv
// tb_tmip_act_sched: scoreboard bench for tmip_act_sched. Each action burst is run through
// a list-based reference model that pushes the expected commands and set index into
// queues; a monitor pops and compares on every command transfer and set_done pulse.
module tb_tmip_act_sched;
  localparam int QDEPTH = 8;
  localparam int SETS   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tmip_act_sched_if bus_if ();

  tmip_act_sched #(.QDEPTH(QDEPTH), .SETS(SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [5:0] exp_cmd[$];
  logic [2:0] exp_idx[$];
  int err_seen = 0, err_exp = 0;
  int sets_seen = 0, sets_exp = 0, xfer_cnt = 0;
  int sets_since = SETS;  // nothing loaded yet: sets are rejected
  int base = 0;
  bit rand_ready = 0, ready_manual = 0;
  int dly_fixed = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int outs();
    logic [13:0] v;
    v = {bus_if.cmd_valid, bus_if.cmd_op, bus_if.cmd_size, bus_if.cmd_last,
         bus_if.set_done, bus_if.set_idx, bus_if.busy, bus_if.proto_err};
    return int'(v);
  endfunction

  // Monitor / scoreboard
  initial begin
    logic       pv, pr;
    logic [5:0] pcmd, cur;
    logic [5:0] e;
    logic [2:0] ei;
    pv = 1'b0; pr = 1'b0; pcmd = '0;
    forever begin
      @(negedge clk);
      cur = {bus_if.cmd_op, bus_if.cmd_size, bus_if.cmd_last};
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", int'(bus_if.cmd_valid), 1);
          check("hold_cmd", int'(cur), int'(pcmd));
        end
        if (bus_if.proto_err) err_seen++;
        if (bus_if.cmd_valid && bus_if.cmd_ready) begin
          xfer_cnt++;
          if (exp_cmd.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_cmd: got op=%0d size=%0d last=%0d, expected none",
                     cur[5:3], cur[2:1], cur[0]);
          end else begin
            e = exp_cmd.pop_front();
            check("cmd{op,size,last}", int'(cur), int'(e));
          end
        end
        if (bus_if.set_done) begin
          sets_seen++;
          if (exp_idx.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_set_done: got set_idx=%0d, expected none", bus_if.set_idx);
          end else begin
            ei = exp_idx.pop_front();
            check("set_idx", int'(bus_if.set_idx), int'(ei));
          end
        end
        pv = bus_if.cmd_valid;
        pr = bus_if.cmd_ready;
        pcmd = cur;
      end
    end
  end

  // Datapath responder: one dp_done pulse some cycles after each transfer
  initial begin
    int d;
    bus_if.dp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.cmd_valid && bus_if.cmd_ready) begin
        d = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1 bus_if.dp_done = 1'b1;
        @(posedge clk);
        #1 bus_if.dp_done = 1'b0;
      end
    end
  end

  // cmd_ready driver
  initial begin
    bus_if.cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!ready_manual) bus_if.cmd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Reference model: returns expected proto_err pulses, pushes expected commands
  function automatic int model(input int acts[$]);
    int q[$];
    bit ovf = 0;
    int e = 0;
    int cur = base;
    logic l;
    foreach (acts[i]) begin
      if ((acts[i] == 4 || acts[i] == 5) && q.size() > 0 && q[q.size()-1] == acts[i]) begin
        void'(q.pop_back());
      end else if (q.size() == QDEPTH) begin
        if (!ovf) e++;
        ovf = 1;
      end else begin
        q.push_back(acts[i]);
      end
    end
    if (q.size() == 0 || q[q.size()-1] != 7) e++;
    foreach (q[i]) begin
      if (q[i] == 3 && cur == 0) continue;
      l = (i == q.size() - 1);
      exp_cmd.push_back({3'(q[i]), 2'(cur), l});
      if (q[i] == 3) cur--;
    end
    return e;
  endfunction

  task automatic drive_burst(input int acts[$]);
    foreach (acts[i]) begin
      @(posedge clk); #1;
      bus_if.in_valid2 = 1'b1;
      bus_if.action = 3'(acts[i]);
    end
    @(posedge clk); #1;
    bus_if.in_valid2 = 1'b0;
  endtask

  task automatic load_image(input int sz);
    int h = $urandom_range(0, 2);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.image_size = 2'(sz);
    repeat (h) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    base = (sz == 3) ? 2 : sz;
    if (sz == 3) err_exp++;
    sets_since = 0;
    repeat (3) @(posedge clk);
    #1 check("load_proto_err_count", err_seen, err_exp);
  endtask

  task automatic wait_sets(input int target);
    int n = 0;
    while (sets_seen < target && n < 3000) begin @(negedge clk); n++; end
    if (sets_seen < target) begin
      n_bad++; n_cmp++;
      $display("FAIL set_done_timeout: got %0d sets, expected %0d", sets_seen, target);
    end
  endtask

  task automatic run_set(input int acts[$], input bit hold);
    if (sets_since >= SETS) begin
      drive_burst(acts);
      err_exp++;
      repeat (6) @(posedge clk);
    end else begin
      err_exp += model(acts);
      exp_idx.push_back(3'(sets_since));
      sets_since++;
      sets_exp++;
      drive_burst(acts);
      if (hold) begin
        ready_manual = 1;
        bus_if.cmd_ready = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        ready_manual = 0;
      end
      wait_sets(sets_exp);
      repeat (3) @(posedge clk);
    end
    #1;
    check("cmds_drained", exp_cmd.size(), 0);
    check("busy_when_idle", int'(bus_if.busy), 0);
    check("proto_err_count", err_seen, err_exp);
  endtask

  task automatic rand_acts(output int acts[$]);
    int len = $urandom_range(1, 10);
    int a, prev = -1;
    acts.delete();
    for (int k = 0; k < len; k++) begin
      a = $urandom_range(0, 7);
      if ((prev == 4 || prev == 5) && $urandom_range(0, 2) == 0) a = prev;
      if (k == len - 1 && $urandom_range(0, 9) < 7) a = 7;
      acts.push_back(a);
      prev = a;
    end
  endtask

  initial begin
    int acts[$];
    int t1[4], t2[4], t3[5], t4[10], t6[3];
    int start, n;
    t1 = '{1, 3, 3, 7};
    t2 = '{0, 3, 6, 7};
    t3 = '{2, 5, 5, 4, 7};
    t4 = '{1, 2, 0, 6, 1, 2, 0, 7, 6, 5};
    t6 = '{1, 6, 7};
    bus_if.in_valid = 1'b0;
    bus_if.image_size = 2'd0;
    bus_if.in_valid2 = 1'b0;
    bus_if.action = 3'd0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs(), 0);
    rst_n = 1'b1;

    // Directed sets
    dly_fixed = 5;
    load_image(2);
    acts.delete(); foreach (t1[i]) acts.push_back(t1[i]);
    run_set(acts, 0);
    dly_fixed = 0;
    load_image(0);
    acts.delete(); foreach (t2[i]) acts.push_back(t2[i]);
    run_set(acts, 0);
    acts.delete(); foreach (t3[i]) acts.push_back(t3[i]);
    run_set(acts, 0);
    load_image(2);
    acts.delete(); foreach (t4[i]) acts.push_back(t4[i]);
    run_set(acts, 1);

    // Eight sets exhaust the image; the ninth burst is rejected
    rand_ready = 1;
    load_image($urandom_range(0, 3));
    for (int s = 0; s < SETS + 1; s++) begin
      rand_acts(acts);
      run_set(acts, 0);
    end

    // Reset while waiting for dp_done
    rand_ready = 0;
    dly_fixed = 5;
    load_image(2);
    acts.delete(); foreach (t6[i]) acts.push_back(t6[i]);
    err_exp += model(acts);
    start = xfer_cnt;
    drive_burst(acts);
    n = 0;
    while (xfer_cnt == start && n < 200) begin @(negedge clk); n++; end
    check("first_xfer_seen", int'(xfer_cnt > start), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check("async_reset_outputs", outs(), 0);
    exp_cmd.delete();
    exp_idx.delete();
    sets_since = SETS;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("no_err_after_reset", err_seen, err_exp);
    dly_fixed = 0;
    load_image(1);
    acts.delete(); foreach (t1[i]) acts.push_back(t1[i]);
    run_set(acts, 0);

    // Random images and sets
    rand_ready = 1;
    for (int img = 0; img < 4; img++) begin
      load_image($urandom_range(0, 3));
      n = $urandom_range(1, 5);
      for (int s = 0; s < n; s++) begin
        rand_acts(acts);
        run_set(acts, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
